apb_req_master: RTL

- Upstream stage for the timer's APB slave port: converts a simple valid/ready register-request stream into APB3 transactions and returns a single response per request.
- Placed between the system request source (CPU/test controller) and the timer's tim_psel/tim_penable/tim_pwrite/tim_paddr/tim_pwdata inputs.
- One outstanding transfer at a time; includes a misalignment check and an access-phase timeout.

---
 rtl/apb_req_master_pkg.sv | 17 +
 rtl/apb_req_master_if.sv | 37 +++
 rtl/apb_req_master.sv | 79 +++++++
 3 files changed

// File: rtl/apb_req_master_pkg.sv
// apb_req_pkg: shared FSM state type, alignment mask and timer register map
package apb_req_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [1:0] APB_ALIGN_MASK = 2'b11;

    localparam logic [11:0] TCR   = 12'h000;
    localparam logic [11:0] TDR0  = 12'h004;
    localparam logic [11:0] TDR1  = 12'h008;
    localparam logic [11:0] TCMP0 = 12'h00C;
    localparam logic [11:0] TCMP1 = 12'h010;
    localparam logic [11:0] TIER  = 12'h014;
    localparam logic [11:0] TISR  = 12'h018;
    localparam logic [11:0] THCSR = 12'h01C;

endpackage

// File: rtl/apb_req_master_if.sv
// apb_req_master_if: request/response stream plus APB3 bus seen by the request master
interface apb_req_master_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              apb_psel;
    logic              apb_penable;
    logic              apb_pwrite;
    logic [ADDR_W-1:0] apb_paddr;
    logic [DATA_W-1:0] apb_pwdata;
    logic [DATA_W-1:0] apb_prdata;
    logic              apb_pready;
    logic              apb_pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  apb_prdata, apb_pready, apb_pslverr,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        output apb_prdata, apb_pready, apb_pslverr,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata
    );
endinterface

// File: rtl/apb_req_master.sv
// apb_req_master: one-at-a-time valid/ready request to APB3 transfer bridge
// with misalignment rejection and an access-phase timeout.
module apb_req_master
    import apb_req_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic sys_clk,
    input  logic sys_rst,
    apb_req_master_if.master bus
);
    localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;

    state_t            state, state_nx;
    logic              wr_q, err_q, misalign, timeout;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [CW-1:0]     cnt;

    assign misalign = |(bus.req_addr[1:0] & APB_ALIGN_MASK);
    // pready has priority over an expiring timeout
    assign timeout  = TIMEOUT_CYC != 0 && cnt == CW'(TIMEOUT_CYC - 1) && !bus.apb_pready;

    always_comb begin
        state_nx        = state;
        bus.req_ready   = state == IDLE;
        bus.resp_valid  = state == RESP;
        bus.apb_psel    = state == SETUP || state == ACCESS;
        bus.apb_penable = state == ACCESS;
        bus.apb_pwrite  = wr_q;
        bus.apb_paddr   = addr_q;
        bus.apb_pwdata  = wdata_q;
        bus.resp_rdata  = rdata_q;
        bus.resp_err    = err_q;
        case (state)
            IDLE:    state_nx = bus.req_valid ? (misalign ? RESP : SETUP) : IDLE;
            SETUP:   state_nx = ACCESS;
            ACCESS:  state_nx = bus.apb_pready || timeout ? RESP : ACCESS;
            default: state_nx = bus.resp_ready ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.req_valid) begin
                rdata_q <= '0;
                err_q   <= misalign;
                // a rejected request never reaches the bus, so leave the bus values alone
                if (!misalign) begin
                    wr_q    <= bus.req_write;
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                end
            end
            if (state == SETUP)
                cnt <= '0;
            else if (state == ACCESS && cnt != CW'(TIMEOUT_CYC))
                cnt <= cnt + 1'b1;
            if (state == ACCESS && bus.apb_pready) begin
                rdata_q <= wr_q ? '0 : bus.apb_prdata;
                err_q   <= bus.apb_pslverr;
            end else if (state == ACCESS && timeout) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end
endmodule
